// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding and bus constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_FETCH,
    IF_HOLD
  } if_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [3:0]  BYTE_EN_ALL = 4'hF;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that parks a returned instruction while decode is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] data_q;
  logic [31:0] pc_q;

  // Occupancy flag: set on load, cleared on unload; load takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload capture; contents are meaningless while valid_q is low, so no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
      pc_q   <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues imem reads from the PC stream, stalls the PC,
// and hands a registered instruction/PC pair to decode with a one-word skid buffer.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  input  logic             pc_active,
  input  logic             fetch_stall,
  input  logic             decode_stall,
  output logic             pc_stall,
  output logic [31:0]      imem_address,
  output logic             imem_read,
  output logic [3:0]       imem_byteenable,
  input  logic             imem_waitrequest,
  input  logic [31:0]      imem_readdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  import cpu_pkg::*;

  if_state_t        state_q, state_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic             rd_active;
  logic             mem_done;
  logic             can_take;
  logic             accept;
  logic             buf_load;
  logic             buf_unload;
  logic             buf_valid;
  logic [31:0]      buf_data;
  logic [31:0]      buf_pc;

  // Handshake terms: a word is taken straight into if_* only if the output slot is free or draining.
  always_comb begin
    rd_active  = (state_q == IF_FETCH);
    mem_done   = rd_active && !imem_waitrequest;
    can_take   = !if_valid_q || !decode_stall;
    accept     = mem_done && can_take;
    buf_load   = mem_done && !can_take;
    buf_unload = (state_q == IF_HOLD) && buf_valid && !decode_stall;
  end

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (buf_load),
    .unload_i (buf_unload),
    .data_i   (imem_readdata),
    .pc_i     (req_addr_q),
    .valid_o  (buf_valid),
    .data_o   (buf_data),
    .pc_o     (buf_pc)
  );

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      IF_IDLE: begin
        if (pc_active) begin
          req_addr_d = pc_in;
          state_d    = IF_FETCH;
        end
      end
      IF_FETCH: begin
        if (accept) begin
          if (pc_active) begin
            req_addr_d = pc_in;
          end else begin
            state_d = IF_IDLE;
          end
        end else if (buf_load) begin
          state_d = IF_HOLD;
        end
      end
      IF_HOLD: begin
        if (buf_unload) begin
          if (pc_active) begin
            req_addr_d = pc_in;
            state_d    = IF_FETCH;
          end else begin
            state_d = IF_IDLE;
          end
        end
      end
      default: state_d = IF_IDLE;
    endcase

    // Output slot: a fresh word or the parked word replaces the current one; otherwise drain to NOP.
    if (accept) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_readdata;
      if_pc_d    = req_addr_q;
    end else if (buf_unload) begin
      if_valid_d = 1'b1;
      if_instr_d = buf_data;
      if_pc_d    = buf_pc;
    end else if (!decode_stall) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end

    // Every word returned by memory is counted once, whether it lands in if_* or the skid buffer.
    if (mem_done) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end

    if (rd_active && (req_addr_q[1:0] != 2'b00)) begin
      misaligned_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset; an in-flight read is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IF_IDLE;
      req_addr_q    <= 32'h0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= 32'h0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
      assert (fetch_stall == pc_stall);
    end
  end

  assign pc_stall = ((state_q == IF_FETCH) && (imem_waitrequest || (if_valid_q && decode_stall)))
                    || (state_q == IF_HOLD);

  assign imem_address    = req_addr_q;
  assign imem_read       = rd_active;
  assign imem_byteenable = BYTE_EN_ALL;
  assign if_valid        = if_valid_q;
  assign if_instr        = if_instr_q;
  assign if_pc           = if_pc_q;
  assign misaligned      = misaligned_q;
  assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch scenarios, decode-side monitor.
module tb_instr_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_active;
  logic        fetch_stall;
  logic        decode_stall;
  logic        pc_stall;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [3:0]  imem_byteenable;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misaligned;
  logic [31:0] fetch_count;

  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] pc_reg;
  logic        mon_en;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .pc_in            (pc_in),
    .pc_active        (pc_active),
    .fetch_stall      (fetch_stall),
    .decode_stall     (decode_stall),
    .pc_stall         (pc_stall),
    .imem_address     (imem_address),
    .imem_read        (imem_read),
    .imem_byteenable  (imem_byteenable),
    .imem_waitrequest (imem_waitrequest),
    .imem_readdata    (imem_readdata),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .misaligned       (misaligned),
    .fetch_count      (fetch_count)
  );

  // PC register model: holds while pc_stall, advances by one word otherwise.
  always @(posedge clk) begin
    if (pc_load) pc_reg <= pc_load_val;
    else if (pc_active && !pc_stall) pc_reg <= pc_reg + 32'd4;
  end

  assign pc_in       = pc_reg;
  assign fetch_stall = pc_stall;
  // Memory model: word at BASE+4k holds 0x24020001+k.
  assign imem_readdata = 32'h2402_0001 + ((imem_address - BASE) >> 2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_q.push_back({instr, pc});
  endtask

  // Decode-side monitor: every word decode takes must match the next expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (if_valid === 1'b1 && decode_stall === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h at %h expected none", if_instr, if_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_instr", if_instr, e[63:32]);
            check("sb_pc", if_pc, e[31:0]);
          end
        end else if (if_valid !== 1'b1) begin
          check("nop_when_invalid", if_instr, NOP);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    mon_en = 1'b0;
    rst = 1'b1;
    pc_active = 1'b0;
    decode_stall = 1'b0;
    imem_waitrequest = 1'b0;
    pc_load = 1'b1;
    pc_load_val = BASE;
    step();
    step();

    // Reset state
    check("rst_imem_read", {31'b0, imem_read}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_pc_stall", {31'b0, pc_stall}, 32'd0);
    check("byteenable", {28'b0, imem_byteenable}, 32'hF);

    // Zero-wait stream of four words
    rst = 1'b0;
    pc_load = 1'b0;
    pc_active = 1'b1;
    mon_en = 1'b1;
    push(32'h2402_0001, BASE);
    push(32'h2402_0002, BASE + 32'd4);
    push(32'h2402_0003, BASE + 32'd8);
    push(32'h2402_0004, BASE + 32'd12);
    step();
    check("first_addr", imem_address, BASE);
    check("first_read", {31'b0, imem_read}, 32'd1);
    check("stream_stall0", {31'b0, pc_stall}, 32'd0);
    step();
    check("first_valid", {31'b0, if_valid}, 32'd1);
    check("first_pc", if_pc, BASE);
    check("stream_addr1", imem_address, BASE + 32'd4);
    check("stream_stall1", {31'b0, pc_stall}, 32'd0);
    step();
    check("stream_stall2", {31'b0, pc_stall}, 32'd0);
    step();
    check("stream_stall3", {31'b0, pc_stall}, 32'd0);
    pc_active = 1'b0;
    step();
    check("stream_last", if_instr, 32'h2402_0004);
    check("stream_count", fetch_count, 32'd4);
    check("stream_idle_read", {31'b0, imem_read}, 32'd0);
    step();
    check("stream_drained", {31'b0, if_valid}, 32'd0);

    // Three wait states
    push(32'h2402_0005, BASE + 32'h10);
    imem_waitrequest = 1'b1;
    pc_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_read", {31'b0, imem_read}, 32'd1);
      check("wait_addr", imem_address, BASE + 32'h10);
      check("wait_stall", {31'b0, pc_stall}, 32'd1);
      check("wait_no_valid", {31'b0, if_valid}, 32'd0);
    end
    imem_waitrequest = 1'b0;
    pc_active = 1'b0;
    step();
    check("wait_accept_instr", if_instr, 32'h2402_0005);
    check("wait_accept_count", fetch_count, 32'd5);
    step();

    // Decode back-pressure into the hold buffer
    push(32'h2402_0006, BASE + 32'h14);
    push(32'h2402_0007, BASE + 32'h18);
    pc_active = 1'b1;
    step();
    check("hold_addr0", imem_address, BASE + 32'h14);
    step();
    check("hold_first", if_instr, 32'h2402_0006);
    decode_stall = 1'b1;
    step();
    check("hold_read", {31'b0, imem_read}, 32'd0);
    check("hold_stall", {31'b0, pc_stall}, 32'd1);
    check("hold_keep", if_instr, 32'h2402_0006);
    check("hold_count", fetch_count, 32'd7);
    pc_active = 1'b0;
    step();
    check("hold_read2", {31'b0, imem_read}, 32'd0);
    check("hold_stall2", {31'b0, pc_stall}, 32'd1);
    check("hold_keep2", if_instr, 32'h2402_0006);
    decode_stall = 1'b0;
    step();
    check("hold_release_instr", if_instr, 32'h2402_0007);
    check("hold_release_pc", if_pc, BASE + 32'h18);
    check("hold_release_valid", {31'b0, if_valid}, 32'd1);
    step();
    check("hold_done_valid", {31'b0, if_valid}, 32'd0);
    check("hold_done_count", fetch_count, 32'd7);

    // Misaligned request
    pc_load = 1'b1;
    pc_load_val = BASE + 32'd2;
    step();
    pc_load = 1'b0;
    pc_active = 1'b1;
    push(32'h2402_0001, BASE + 32'd2);
    step();
    check("mis_addr", imem_address, BASE + 32'd2);
    check("mis_before", {31'b0, misaligned}, 32'd0);
    pc_active = 1'b0;
    step();
    check("mis_set", {31'b0, misaligned}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mis_sticky", {31'b0, misaligned}, 32'd1);
    end

    // Reset during a waiting fetch
    pc_load = 1'b1;
    pc_load_val = BASE + 32'h100;
    step();
    pc_load = 1'b0;
    imem_waitrequest = 1'b1;
    pc_active = 1'b1;
    step();
    check("rstmid_read_before", {31'b0, imem_read}, 32'd1);
    rst = 1'b1;
    step();
    check("rstmid_read", {31'b0, imem_read}, 32'd0);
    check("rstmid_valid", {31'b0, if_valid}, 32'd0);
    check("rstmid_count", fetch_count, 32'd0);
    check("rstmid_misaligned", {31'b0, misaligned}, 32'd0);
    check("rstmid_instr", if_instr, NOP);
    rst = 1'b0;
    pc_active = 1'b0;
    imem_waitrequest = 1'b0;
    step();
    step();
    check("post_rst_read", {31'b0, imem_read}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
